trig_decoder: RTL

- Receive-side counterpart of the 3-line CFEB trigger encoding; one instance per CFEB link.
- Samples the 3 trigger lines and decodes them into single-cycle PRE_LCT, L1A, L1A_MATCH and RESYNC strobes.
- Supports both encoded mode and direct (unencoded) line mode.
- Qualifies RESYNC by minimum run length and keeps L1A and code-error counters for slow-control readback.

---
 rtl/trig_code_pkg.sv | 57 +++++
 rtl/trig_decoder_resync_qualifier.sv | 83 ++++++++
 rtl/trig_decoder.sv | 95 +++++++++
 3 files changed

// File: rtl/trig_code_pkg.sv
// Shared CFEB trigger-line code definitions, used by both the encoder and the decoder.
// Also provides the resync FSM state type and the line decode helper.
package trig_code_pkg;

    localparam logic [2:0] CODE_NONE          = 3'd0;
    localparam logic [2:0] CODE_PRE           = 3'd1;
    localparam logic [2:0] CODE_L1A_PRE       = 3'd2;
    localparam logic [2:0] CODE_L1A_MATCH_PRE = 3'd3;
    localparam logic [2:0] CODE_L1A           = 3'd4;
    localparam logic [2:0] CODE_L1A_MATCH     = 3'd5;
    localparam logic [2:0] CODE_ILLEGAL       = 3'd6;
    localparam logic [2:0] CODE_RESYNC        = 3'd7;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_ARM  = 2'd1,
        RS_HOLD = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic pre_lct;
        logic l1a;
        logic l1a_match;
        logic req;
        logic illegal;
    } trig_dec_t;

    // A resync request always masks the trigger strobes of the same sample.
    function automatic trig_dec_t decode_lines(input logic encode, input logic dcfeb,
                                               input logic [2:0] lines);
        trig_dec_t d;
        d = '0;
        if (encode && !dcfeb) begin
            case (lines)
                CODE_NONE:          d = '0;
                CODE_PRE:           d.pre_lct = 1'b1;
                CODE_L1A_PRE:       begin d.l1a = 1'b1; d.pre_lct = 1'b1; end
                CODE_L1A_MATCH_PRE: begin d.l1a = 1'b1; d.l1a_match = 1'b1; d.pre_lct = 1'b1; end
                CODE_L1A:           d.l1a = 1'b1;
                CODE_L1A_MATCH:     begin d.l1a = 1'b1; d.l1a_match = 1'b1; end
                CODE_ILLEGAL:       d.illegal = 1'b1;
                CODE_RESYNC:        d.req = 1'b1;
                default:            d = '0;
            endcase
        end else begin
            d.req       = lines[2];
            d.l1a       = lines[1];
            d.pre_lct   = lines[0] & ~dcfeb;
            d.l1a_match = lines[0] & dcfeb;
        end
        d.pre_lct   = d.pre_lct & ~d.req;
        d.l1a       = d.l1a & ~d.req;
        d.l1a_match = d.l1a_match & ~d.req;
        return d;
    endfunction

endpackage

// File: rtl/trig_decoder_resync_qualifier.sv
// Resync run-length qualifier: fires once after RESYNC_MIN consecutive requests,
// flags an abort when a request run ends early.
module resync_qualifier
    import trig_code_pkg::*;
#(
    parameter int unsigned RESYNC_MIN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic fire,
    output logic abort
);

    localparam logic [3:0] MIN_C = 4'(RESYNC_MIN);

    rs_state_t  state_r;
    rs_state_t  state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Next-state, run counter and fire/abort decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        fire        = 1'b0;
        abort       = 1'b0;
        case (state_r)
            RS_IDLE: begin
                if (req) begin
                    if (MIN_C == 4'd1) begin
                        fire        = 1'b1;
                        state_nxt_s = RS_HOLD;
                    end else begin
                        cnt_nxt_s   = 4'd1;
                        state_nxt_s = RS_ARM;
                    end
                end else begin
                    cnt_nxt_s = 4'd0;
                end
            end
            RS_ARM: begin
                if (req) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                    if ((cnt_r + 4'd1) == MIN_C) begin
                        fire        = 1'b1;
                        state_nxt_s = RS_HOLD;
                    end else begin
                        state_nxt_s = RS_ARM;
                    end
                end else begin
                    abort       = 1'b1;
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = RS_IDLE;
                end
            end
            RS_HOLD: begin
                if (req) begin
                    state_nxt_s = RS_HOLD;
                end else begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = RS_IDLE;
                end
            end
            default: begin
                cnt_nxt_s   = 4'd0;
                state_nxt_s = RS_IDLE;
            end
        endcase
    end

    // State and run-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RS_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/trig_decoder.sv
// Receive-side decoder for the 3-line CFEB trigger encoding: two-stage pipeline
// producing trigger strobes, qualified RESYNC and slow-control counters.
module trig_decoder
    import trig_code_pkg::*;
#(
    parameter int unsigned RESYNC_MIN = 2,
    parameter int unsigned L1A_CNT_W  = 24,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENCODE,
    input  logic                 DCFEB_IN_USE,
    input  logic [2:0]           ENC_IN,
    output logic                 PRE_LCT,
    output logic                 L1A,
    output logic                 L1A_MATCH,
    output logic                 RESYNC,
    output logic                 CODE_ERR,
    output logic [L1A_CNT_W-1:0] L1A_CNT,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    logic [2:0] enc_in_r;
    logic       encode_r;
    logic       dcfeb_r;
    trig_dec_t  dec_s;
    logic       fire_s;
    logic       abort_s;

    // Stage 1: lines and mode bits captured together so a mode switch is sample-coherent.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            enc_in_r <= 3'd0;
            encode_r <= 1'b0;
            dcfeb_r  <= 1'b0;
        end else begin
            enc_in_r <= ENC_IN;
            encode_r <= ENCODE;
            dcfeb_r  <= DCFEB_IN_USE;
        end
    end

    assign dec_s = decode_lines(encode_r, dcfeb_r, enc_in_r);

    resync_qualifier #(
        .RESYNC_MIN (RESYNC_MIN)
    ) u_resync_qualifier (
        .clk   (CLK),
        .rst_n (RST_N),
        .req   (dec_s.req),
        .fire  (fire_s),
        .abort (abort_s)
    );

    // Stage 2: registered strobes.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PRE_LCT   <= 1'b0;
            L1A       <= 1'b0;
            L1A_MATCH <= 1'b0;
            RESYNC    <= 1'b0;
            CODE_ERR  <= 1'b0;
        end else begin
            PRE_LCT   <= dec_s.pre_lct;
            L1A       <= dec_s.l1a;
            L1A_MATCH <= dec_s.l1a_match;
            RESYNC    <= fire_s;
            CODE_ERR  <= dec_s.illegal | abort_s;
        end
    end

    // Counters follow the output strobes; a RESYNC clears them on the next edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            L1A_CNT <= '0;
            ERR_CNT <= '0;
        end else if (RESYNC) begin
            L1A_CNT <= '0;
            ERR_CNT <= '0;
        end else begin
            if (L1A) begin
                L1A_CNT <= L1A_CNT + L1A_CNT_W'(1'b1);
            end else begin
                L1A_CNT <= L1A_CNT;
            end
            if (CODE_ERR && (ERR_CNT != {ERR_CNT_W{1'b1}})) begin
                ERR_CNT <= ERR_CNT + ERR_CNT_W'(1'b1);
            end else begin
                ERR_CNT <= ERR_CNT;
            end
        end
    end

endmodule
